segment_runner: RTL and testbench
=================================

// Module: segment_runner
// PURPOSE
//  Consumer side of the switch sequencer: takes a step request (segment index + per-step write flags),
//  loads the picoMIPS PC with that segment's start address, runs the core until the segment halts,
//  and commits switch data into the register file when the step carries a write flag.
//  Sits between the sequencer and the picoMIPS core (PC, register file write port, decoder halt).
// PARAMETERS
//  N        8   data bus width (switch data, register file write data)
//  PC_W     6   program counter width
//  NSEG     5   number of segment start-address slots
//  NREG     5   width of one-hot register write-select
//  TMO_W    8   run watchdog counter width (used only with SEG_TIMEOUT_EN)
// PORTS
//  clk        in   1            system clock, rising edge
//  reset      in   1            synchronous, active-high
//  step       in   1            one-cycle step request; accepted only while ready=1
//  seg_sel    in   3            segment index 0..NSEG-1, sampled with step
//  seg_addr   in   NSEG x PC_W  start-address table, sampled with step
//  writein    in   NREG         one-hot register write-select for this step; 0 = no write
//  sw_data    in   N            switch data to commit when writein != 0
//  halt       in   1            from core decoder: current instruction is segment end
//  ready      out  1            1 in IDLE only
//  pc_load    out  1            one-cycle PC load strobe to core
//  pc_addr    out  PC_W         address presented with pc_load
//  run_en     out  1            core clock-enable; 1 only in RUN
//  rf_we      out  1            one-cycle register file write strobe
//  rf_sel     out  NREG         one-hot register select, valid with rf_we
//  rf_wdata   out  N            write data, valid with rf_we
//  done       out  1            one-cycle pulse at segment completion
//  err        out  1            sticky: bad seg_sel (or watchdog expiry); cleared by reset or next accepted step
// BEHAVIOUR
//  Reset: state IDLE; ready=1; pc_load, run_en, rf_we, done, err = 0; pc_addr, rf_sel, rf_wdata = 0.
//  States: IDLE -> WRITE (writein!=0) | LOAD (writein==0); WRITE -> LOAD; LOAD -> RUN; RUN -> DONE on halt; DONE -> IDLE.
//  Accept: step && ready; latch seg_sel, seg_addr[seg_sel], writein, sw_data into holding regs; clear err.
//  step while ready=0 is ignored (no queueing).
//  seg_sel >= NSEG: err=1, no write, no load, stay IDLE; ready stays 1.
//  writein not one-hot and nonzero: treated as bad request, same as bad seg_sel.
//  WRITE: rf_we=1 one cycle, rf_sel=latched writein, rf_wdata=latched sw_data.
//  LOAD: pc_load=1 one cycle, pc_addr=latched address; pc_addr holds value until next LOAD.
//  Latency step->pc_load: 1 cycle (no write), 2 cycles (write).
//  RUN: run_en=1; halt sampled each cycle; halt in the same cycle RUN is entered counts.
//  DONE: run_en=0, done=1 one cycle, then IDLE (ready=1 next cycle).
//  rf_we and pc_load never asserted in the same cycle; done never coincides with ready.
//  reset mid-RUN/WRITE: all strobes drop next edge, no partial write beyond cycle already issued.
//  seg_addr may change after accept without effect; address wraps naturally in PC_W bits (core's concern).
// CONFIGURATION
//  SEG_TIMEOUT_EN defined: TMO_W-bit counter cleared on entry to RUN, increments each RUN cycle;
//   reaching all-ones without halt -> err=1, run_en=0, DONE (done pulses). halt on that same cycle wins (no err).
//  SEG_TIMEOUT_EN undefined: no counter; RUN waits for halt indefinitely; err only from bad requests.
// STRUCTURE
//  Package segment_pkg: state enum (IDLE, WRITE, LOAD, RUN, DONE), NSEG, PC_W, NREG defaults,
//   function onehot_ok(writein).
//  One sub-module natural: step_sync -- converts raw sequencer toggle (SW[8] level) into the single-cycle step
//   pulse; instantiated by the top, not inside segment_runner. segment_runner itself is one FSM plus hold regs.
// TESTING
//  reset, step seg_sel=0 seg_addr[0]=6 writein=0 -> pc_load at +1 with pc_addr=6, run_en until halt, done pulse.
//  step seg_sel=1 seg_addr[1]=8 writein=00100 sw_data=0x5A -> rf_we at +1 (sel=00100,data=0x5A), pc_load=8 at +2.
//  step seg_sel=6 -> err=1, no rf_we/pc_load, ready=1; next valid step clears err.
//  step during RUN (seg_sel=3) -> ignored; after done, pc_addr unchanged, no second load.
//  reset asserted 2 cycles into RUN -> run_en=0, ready=1 next edge, all outputs at reset values.
//  SEG_TIMEOUT_EN, TMO_W=4, halt never -> err=1 and done after 15 RUN cycles; halt on cycle 15 -> err=0.

Source files
------------

// File: rtl/segment_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : segment_pkg
//  Description: Shared types and helpers for the segment runner: FSM state
//               encoding, default geometry and the write-select sanity check.
//  Revision   : 1.0  initial release
// ============================================================================
package segment_pkg;

  localparam int NSEG_DEF = 5;
  localparam int PC_W_DEF = 6;
  localparam int NREG_DEF = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // True when the write-select has at most one bit set (zero means "no write").
  function automatic logic onehot_ok(input logic [31:0] v);
    return (v & (v - 32'd1)) == 32'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/segment_runner.sv
`default_nettype none
// ============================================================================
//  Module     : segment_runner
//  Description: Accepts a step request (segment index + optional register
//               write), commits the switch data, loads the core PC with the
//               segment start address and runs the core until it halts.
//               Optional run watchdog enabled by defining SEG_TIMEOUT_EN.
//  Revision   : 1.0  initial release
// ============================================================================
module segment_runner
  import segment_pkg::*;
#(
  parameter int N    = 8,
  parameter int PC_W = PC_W_DEF,
  parameter int NSEG = NSEG_DEF,
  parameter int NREG = NREG_DEF
`ifdef SEG_TIMEOUT_EN
  ,
  parameter int TMO_W = 8
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       step,
  input  logic [2:0]                 seg_sel,
  input  logic [NSEG-1:0][PC_W-1:0]  seg_addr,
  input  logic [NREG-1:0]            writein,
  input  logic [N-1:0]               sw_data,
  input  logic                       halt,
  output logic                       ready,
  output logic                       pc_load,
  output logic [PC_W-1:0]            pc_addr,
  output logic                       run_en,
  output logic                       rf_we,
  output logic [NREG-1:0]            rf_sel,
  output logic [N-1:0]               rf_wdata,
  output logic                       done,
  output logic                       err
);

  state_t            r_state;
  state_t            w_next;
  logic [NREG-1:0]   r_sel;
  logic [N-1:0]      r_data;
  logic [PC_W-1:0]   r_addr;
  logic [PC_W-1:0]   r_pc_addr;
  logic              r_err;

  logic              w_accept;
  logic              w_req_ok;
  logic              w_tmo_hit;
  logic [31:0]       w_wr32;
  logic              w_ready;
  logic              w_pc_load;
  logic              w_run_en;
  logic              w_rf_we;
  logic              w_done;

  assign w_wr32   = 32'(writein);
  // A request is usable only with an existing segment and at most one write target.
  assign w_req_ok = (32'(seg_sel) < 32'(NSEG)) && onehot_ok(w_wr32);
  assign w_accept = step && (r_state == S_IDLE);

`ifdef SEG_TIMEOUT_EN
  // The counter starts at zero on the first RUN cycle, so the value one below
  // all-ones marks the last RUN cycle before the watchdog fires.
  localparam logic [TMO_W-1:0] c_TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] c_TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  logic [TMO_W-1:0] r_tmo;

  assign w_tmo_hit = (r_tmo == c_TMO_LAST);

  // Watchdog: cleared while loading, counts every RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (r_state == S_LOAD) begin
      r_tmo <= '0;
    end else if (r_state == S_RUN) begin
      r_tmo <= r_tmo + c_TMO_ONE;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Next-state and strobe decode; all strobes are pure functions of state.
  always_comb begin
    w_next    = r_state;
    w_ready   = 1'b0;
    w_pc_load = 1'b0;
    w_run_en  = 1'b0;
    w_rf_we   = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (w_accept && w_req_ok) begin
          w_next = (writein != '0) ? S_WRITE : S_LOAD;
        end
      end
      S_WRITE: begin
        w_rf_we = 1'b1;
        w_next  = S_LOAD;
      end
      S_LOAD: begin
        w_pc_load = 1'b1;
        w_next    = S_RUN;
      end
      S_RUN: begin
        w_run_en = 1'b1;
        if (halt || w_tmo_hit) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus request holding registers and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_data    <= '0;
      r_addr    <= '0;
      r_pc_addr <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        if (w_req_ok) begin
          r_sel  <= writein;
          r_data <= sw_data;
          r_addr <= seg_addr[seg_sel];
          r_err  <= 1'b0;
        end else begin
          r_err  <= 1'b1;
        end
      end
      // pc_addr only moves on the way into LOAD and then holds until the next load.
      if (w_next == S_LOAD) begin
        r_pc_addr <= (r_state == S_IDLE) ? seg_addr[seg_sel] : r_addr;
      end
      // Watchdog expiry flags an error unless halt arrives in that same cycle.
      if ((r_state == S_RUN) && w_tmo_hit && !halt) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ready    = w_ready;
  assign pc_load  = w_pc_load;
  assign pc_addr  = r_pc_addr;
  assign run_en   = w_run_en;
  assign rf_we    = w_rf_we;
  assign rf_sel   = r_sel;
  assign rf_wdata = r_data;
  assign done     = w_done;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_segment_runner.sv
`default_nettype none
// ============================================================================
//  Module     : tb_segment_runner
//  Description: Self-checking bench for segment_runner with a strobe
//               scoreboard (write / load / done events in order).
//  Revision   : 1.0  initial release
// ============================================================================
module tb_segment_runner;

  logic             clk = 1'b0;
  logic             reset;
  logic             step;
  logic [2:0]       seg_sel;
  logic [4:0][5:0]  seg_addr;
  logic [4:0]       writein;
  logic [7:0]       sw_data;
  logic             halt;
  logic             ready, pc_load, run_en, rf_we, done, err;
  logic [5:0]       pc_addr;
  logic [4:0]       rf_sel;
  logic [7:0]       rf_wdata;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int kind;   // 1 = write, 2 = load, 3 = done
    int a;
    int b;
  } exp_t;
  exp_t q[$];

  segment_runner #(
    .N(8), .PC_W(6), .NSEG(5), .NREG(5)
`ifdef SEG_TIMEOUT_EN
    , .TMO_W(4)
`endif
  ) u_dut (
    .clk(clk), .reset(reset), .step(step), .seg_sel(seg_sel), .seg_addr(seg_addr),
    .writein(writein), .sw_data(sw_data), .halt(halt), .ready(ready), .pc_load(pc_load),
    .pc_addr(pc_addr), .run_en(run_en), .rf_we(rf_we), .rf_sel(rf_sel),
    .rf_wdata(rf_wdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Scoreboard: every strobe must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (rf_we || pc_load || done)) begin
      check("excl_we_ld", int'(rf_we && pc_load), 0);
      check("excl_done_rdy", int'(done && ready), 0);
      if (q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = q.pop_front();
        if (rf_we) begin
          check("sb_kind_wr", 1, e.kind);
          check("sb_rf_sel", int'(rf_sel), e.a);
          check("sb_rf_wdata", int'(rf_wdata), e.b);
        end else if (pc_load) begin
          check("sb_kind_ld", 2, e.kind);
          check("sb_pc_addr", int'(pc_addr), e.a);
        end else begin
          check("sb_kind_done", 3, e.kind);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step(input int sel, input int addr, input int wr, input int data,
                         input bit expect_ok);
    seg_sel = 3'(sel);
    if (sel < 5) seg_addr[sel] = 6'(addr);
    writein = 5'(wr);
    sw_data = 8'(data);
    step    = 1'b1;
    if (expect_ok) begin
      if (wr != 0) q.push_back('{1, wr, data});
      q.push_back('{2, addr, 0});
      q.push_back('{3, 0, 0});
    end
    tick();
    step = 1'b0;
  endtask

  // Wait for RUN, stay n cycles, then halt and check the done/idle handshake.
  task automatic run_seg(input int n);
    int k = 0;
    while (!run_en && k < 10) begin
      tick();
      k++;
    end
    check("run_start", int'(run_en), 1);
    repeat (n - 1) tick();
    check("run_hold", int'(run_en), 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("done_pulse", int'(done), 1);
    check("done_run_en", int'(run_en), 0);
    check("done_ready", int'(ready), 0);
    tick();
    check("idle_ready", int'(ready), 1);
    check("idle_done", int'(done), 0);
  endtask

  initial begin
    reset = 1'b1; step = 1'b0; seg_sel = '0; seg_addr = '0;
    writein = '0; sw_data = '0; halt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values
    check("rst_ready", int'(ready), 1);
    check("rst_pc_load", int'(pc_load), 0);
    check("rst_run_en", int'(run_en), 0);
    check("rst_rf_we", int'(rf_we), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_pc_addr", int'(pc_addr), 0);
    check("rst_rf_sel", int'(rf_sel), 0);
    check("rst_rf_wdata", int'(rf_wdata), 0);

    // Plain step: load one cycle after the step
    do_step(0, 6, 0, 0, 1'b1);
    check("t1_pc_load", int'(pc_load), 1);
    check("t1_pc_addr", int'(pc_addr), 6);
    check("t1_no_we", int'(rf_we), 0);
    run_seg(3);

    // Write step: write at +1, load at +2
    do_step(1, 8, 5'b00100, 8'h5A, 1'b1);
    check("t2_rf_we", int'(rf_we), 1);
    check("t2_rf_sel", int'(rf_sel), 4);
    check("t2_rf_wdata", int'(rf_wdata), 8'h5A);
    check("t2_no_ld", int'(pc_load), 0);
    tick();
    check("t2_pc_load", int'(pc_load), 1);
    check("t2_pc_addr", int'(pc_addr), 8);
    check("t2_we_gone", int'(rf_we), 0);
    run_seg(1);

    // Bad segment index: sticky err, no activity, still ready
    do_step(6, 0, 0, 0, 1'b0);
    check("t3_err", int'(err), 1);
    check("t3_ready", int'(ready), 1);
    check("t3_no_we", int'(rf_we), 0);
    check("t3_no_ld", int'(pc_load), 0);
    tick();
    check("t3_err_sticky", int'(err), 1);
    check("t3_still_idle", int'(ready), 1);
    do_step(2, 6'h15, 0, 0, 1'b1);
    check("t3_err_clr", int'(err), 0);
    check("t3_pc_addr", int'(pc_addr), 6'h15);
    run_seg(2);

    // Non-one-hot write select is a bad request
    do_step(0, 7, 5'b00110, 8'h11, 1'b0);
    check("t3b_err", int'(err), 1);
    check("t3b_no_we", int'(rf_we), 0);
    check("t3b_ready", int'(ready), 1);

    // Address table changing after accept has no effect
    do_step(3, 6'h2A, 5'b00001, 8'hC3, 1'b1);
    check("t4a_err_clr", int'(err), 0);
    check("t4a_rf_wdata", int'(rf_wdata), 8'hC3);
    seg_addr[3] = 6'h00;
    tick();
    check("t4a_pc_addr", int'(pc_addr), 6'h2A);
    run_seg(2);

    // Halt already high in the first RUN cycle ends the segment at once
    do_step(2, 6'h11, 0, 0, 1'b1);
    halt = 1'b1;
    tick();
    check("t5_run1", int'(run_en), 1);
    tick();
    halt = 1'b0;
    check("t5_done", int'(done), 1);
    tick();
    check("t5_ready", int'(ready), 1);

    // Step during RUN is ignored
    do_step(4, 6'h3F, 0, 0, 1'b1);
    tick();
    seg_addr[3] = 6'h01;
    seg_sel = 3'd3;
    writein = 5'b00001;
    step = 1'b1;
    tick();
    step = 1'b0;
    check("t6_still_run", int'(run_en), 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("t6_done", int'(done), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_reload", int'(pc_load), 0);
      check("t6_pc_addr", int'(pc_addr), 6'h3F);
    end

    // Reset two cycles into RUN
    do_step(1, 6'h09, 0, 0, 1'b1);
    tick();
    tick();
    check("t7_in_run", int'(run_en), 1);
    reset = 1'b1;
    q.delete();
    tick();
    check("t7_run_en", int'(run_en), 0);
    check("t7_ready", int'(ready), 1);
    check("t7_pc_addr", int'(pc_addr), 0);
    check("t7_rf_sel", int'(rf_sel), 0);
    check("t7_rf_wdata", int'(rf_wdata), 0);
    check("t7_done", int'(done), 0);
    reset = 1'b0;
    tick();
    check("t7_idle", int'(ready), 1);

`ifdef SEG_TIMEOUT_EN
    // Watchdog: no halt -> 15 RUN cycles, err and done
    begin
      int cnt = 0;
      int k = 0;
      do_step(0, 3, 0, 0, 1'b1);
      while (!run_en && k < 10) begin
        tick();
        k++;
      end
      while (run_en && cnt < 40) begin
        cnt++;
        tick();
      end
      check("tmo_cycles", cnt, 15);
      check("tmo_done", int'(done), 1);
      check("tmo_err", int'(err), 1);
      tick();
      // Halt on the last permitted cycle wins
      do_step(0, 3, 0, 0, 1'b1);
      tick();
      repeat (14) tick();
      check("tmo2_run15", int'(run_en), 1);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      check("tmo2_done", int'(done), 1);
      check("tmo2_err", int'(err), 0);
      tick();
    end
`endif

    repeat (2) tick();
    check("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
